// File: rtl/bus_pkg.sv
// Shared definitions for the maxicore32 bus decoder: address-map constants,
// device class numbers and the bus-cycle FSM state type.
package bus_pkg;

  localparam logic [7:0] IO_CLASS_DEFAULT = 8'h0f;

  localparam int CLASS_PROGRAM = 0;
  localparam int CLASS_MAP     = 1;
  localparam int CLASS_STATUS  = 2;
  localparam int CLASS_LEVELS  = 3;

  // Byte offsets of the IO registers inside the IO class; slot = offset >> 2.
  localparam logic [7:0] IO_LED          = 8'h00;
  localparam logic [7:0] IO_SWITCHES     = 8'h04;
  localparam logic [7:0] IO_UART_DATA    = 8'h08;
  localparam logic [7:0] IO_UART_STATUS  = 8'h0c;
  localparam logic [7:0] IO_TIMER        = 8'h10;
  localparam logic [7:0] IO_TIMER_CTRL   = 8'h14;
  localparam logic [7:0] IO_SPI_DATA     = 8'h18;
  localparam logic [7:0] IO_SPI_CONTROL  = 8'h1c;
  localparam logic [7:0] IO_PWM          = 8'h20;
  localparam logic [7:0] IO_I2C_DATA     = 8'h24;
  localparam logic [7:0] IO_I2C_CONTROL  = 8'h28;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_IO_WAIT,
    ST_DONE,
    ST_ERROR
  } bus_state_e;

  // Bits needed to index n items; never less than one.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_cycle_timer.sv
// Loadable down-counter with zero and last-step flags, shared by the memory
// latency wait and the IO acknowledge timeout.
module bus_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: count_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/bus_decoder.sv
// Address decoder and bus-cycle controller for maxicore32: registered one-hot
// selects, ready handshake, registered read data and fault capture.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int         NUM_CLASSES = 4,
  parameter logic [7:0] IO_CLASS    = IO_CLASS_DEFAULT,
  parameter int         NUM_IO      = 11,
  parameter int         MEM_LATENCY = 1,
  parameter int         TIMEOUT     = 255
) (
  input  logic                      clock,
  input  logic                      n_reset,
  input  logic [29:0]               address,
  input  logic                      read,
  input  logic                      write,
  output logic [NUM_CLASSES-1:0]    class_cs,
  output logic [NUM_IO-1:0]         io_cs,
  input  logic [32*NUM_CLASSES-1:0] class_data,
  input  logic [32*NUM_IO-1:0]      io_data,
  input  logic [NUM_IO-1:0]         io_ack,
  output logic [31:0]               data_in,
  output logic                      ready,
  output logic                      bus_error,
  output logic [29:0]               fault_address,
  output logic [7:0]                fault_count
);

  localparam int CLS_W   = index_width(NUM_CLASSES);
  localparam int IO_W    = index_width(NUM_IO);
  localparam int CNT_MAX = (MEM_LATENCY > TIMEOUT) ? MEM_LATENCY : TIMEOUT;
  localparam int CNT_W   = index_width(CNT_MAX + 1);

  localparam logic [7:0] NUM_CLASSES_B = 8'(NUM_CLASSES);
  localparam logic [6:0] NUM_IO_B      = 7'(NUM_IO);

  bus_state_e state_q, state_d;

  logic [NUM_CLASSES-1:0] class_cs_q, class_cs_d;
  logic [NUM_IO-1:0]      io_cs_q, io_cs_d;
  logic [CLS_W-1:0]       class_idx_q, class_idx_d;
  logic [IO_W-1:0]        slot_q, slot_d;
  logic [31:0]            data_q, data_d;
  logic                   ready_q, ready_d;
  logic [29:0]            fault_addr_q, fault_addr_d;
  logic [7:0]             fault_cnt_q, fault_cnt_d;

  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_value;
  logic                   tmr_dec;
  logic                   tmr_zero;
  logic                   tmr_last;

  logic [7:0]             high_byte;
  logic [5:0]             slot;
  logic                   is_mem;
  logic                   is_io;
  logic [31:0]            class_word [NUM_CLASSES];
  logic [31:0]            io_word    [NUM_IO];

  assign high_byte = address[29:22];
  assign slot      = address[5:0];
  assign is_mem    = (high_byte < NUM_CLASSES_B);
  assign is_io     = (high_byte == IO_CLASS) && ({1'b0, slot} < NUM_IO_B);

  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      class_word[k] = class_data[32*k +: 32];
    end
    for (int s = 0; s < NUM_IO; s++) begin
      io_word[s] = io_data[32*s +: 32];
    end
  end

  bus_cycle_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clock      (clock),
    .n_reset    (n_reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero),
    .last       (tmr_last)
  );

  always_comb begin
    state_d      = state_q;
    class_cs_d   = '0;
    io_cs_d      = '0;
    class_idx_d  = class_idx_q;
    slot_d       = slot_q;
    data_d       = data_q;
    ready_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    fault_cnt_d  = fault_cnt_q;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    tmr_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          if (read && write) begin
            state_d = ST_ERROR;
          end else if (is_mem) begin
            class_idx_d                      = high_byte[CLS_W-1:0];
            class_cs_d[high_byte[CLS_W-1:0]] = 1'b1;
            tmr_load                         = 1'b1;
            tmr_value                        = CNT_W'(MEM_LATENCY);
            state_d                          = ST_MEM_WAIT;
          end else if (is_io) begin
            slot_d                  = slot[IO_W-1:0];
            io_cs_d[slot[IO_W-1:0]] = 1'b1;
            tmr_load                = 1'b1;
            tmr_value               = CNT_W'(TIMEOUT);
            state_d                 = ST_IO_WAIT;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end

      // Completion is decided on the step that takes the count to zero.
      ST_MEM_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          if (read) begin
            data_d = class_word[class_idx_q];
          end
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          class_cs_d = class_cs_q;
        end
      end

      // The ack still wins in the cycle the count sits at zero, giving TIMEOUT+1 chances.
      ST_IO_WAIT: begin
        if (io_ack[slot_q]) begin
          if (read) begin
            data_d = io_word[slot_q];
          end
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else if (tmr_zero) begin
          state_d = ST_ERROR;
        end else begin
          tmr_dec = 1'b1;
          io_cs_d = io_cs_q;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (!read && !write) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
      fault_addr_d = address;
      if (fault_cnt_q != 8'hff) begin
        fault_cnt_d = fault_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      class_cs_q   <= '0;
      io_cs_q      <= '0;
      class_idx_q  <= '0;
      slot_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      class_cs_q   <= class_cs_d;
      io_cs_q      <= io_cs_d;
      class_idx_q  <= class_idx_d;
      slot_q       <= slot_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign class_cs      = class_cs_q;
  assign io_cs         = io_cs_q;
  assign data_in       = data_q;
  assign ready         = ready_q;
  assign bus_error     = (state_q == ST_ERROR);
  assign fault_address = fault_addr_q;
  assign fault_count   = fault_cnt_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: hand-written vector table, randomized
// transactions against a transaction-level timeline model, saturation and reset sequences.
module tb_bus_decoder;

  localparam int NC  = 4;
  localparam int NIO = 11;
  localparam int ML  = 1;
  localparam int TO  = 4;
  localparam logic [7:0] IOC = 8'h0f;

  logic             clock;
  logic             n_reset;
  logic [29:0]      address;
  logic             read;
  logic             write;
  logic [NC-1:0]    class_cs;
  logic [NIO-1:0]   io_cs;
  logic [32*NC-1:0] class_data;
  logic [32*NIO-1:0] io_data;
  logic [NIO-1:0]   io_ack;
  logic [31:0]      data_in;
  logic             ready;
  logic             bus_error;
  logic [29:0]      fault_address;
  logic [7:0]       fault_count;

  bus_decoder #(
    .NUM_CLASSES (NC),
    .IO_CLASS    (IOC),
    .NUM_IO      (NIO),
    .MEM_LATENCY (ML),
    .TIMEOUT     (TO)
  ) dut (
    .clock         (clock),
    .n_reset       (n_reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .class_cs      (class_cs),
    .io_cs         (io_cs),
    .class_data    (class_data),
    .io_data       (io_data),
    .io_ack        (io_ack),
    .data_in       (data_in),
    .ready         (ready),
    .bus_error     (bus_error),
    .fault_address (fault_address),
    .fault_count   (fault_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [29:0]    addr;
    logic           rd;
    logic           wr;
    int             ack;      // cycle in which io_ack is raised, 0 = never
    logic [NC-1:0]  e_ccs;    // class select while the cycle is open
    logic [NIO-1:0] e_ios;    // IO select while the cycle is open
    int             e_ready;  // cycle of the ready pulse, 0 = none
    int             e_err;    // first cycle of bus_error, 0 = none
    logic [31:0]    e_data;
    logic [29:0]    e_faddr;
    int             e_fcnt;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] cword [NC];
  logic [31:0] iword [NIO];
  logic [31:0] m_data;
  logic [29:0] m_faddr;
  int          m_fcnt;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pack_words();
    for (int k = 0; k < NC; k++) class_data[32*k +: 32] = cword[k];
    for (int s = 0; s < NIO; s++) io_data[32*s +: 32] = iword[s];
  endtask

  // Transaction-level expectation built from the address map and timing rules.
  function automatic vec_t predict(input logic [29:0] a, input logic r, input logic w, input int ack);
    vec_t v;
    int   hb;
    int   sl;
    hb = int'(a[29:22]);
    sl = int'(a[5:0]);
    v = '{a, r, w, ack, '0, '0, 0, 0, m_data, m_faddr, m_fcnt};
    if (r && w) begin
      v.e_err = 1;
    end else if (hb < NC) begin
      v.e_ccs   = NC'(1) << hb;
      v.e_ready = ML + 1;
      if (r) v.e_data = cword[hb];
    end else if (hb == int'(IOC) && sl < NIO) begin
      v.e_ios = NIO'(1) << sl;
      if (ack >= 1 && ack <= TO + 1) begin
        v.e_ready = ack + 1;
        if (r) v.e_data = iword[sl];
      end else begin
        v.e_err = TO + 2;
      end
    end else begin
      v.e_err = 1;
    end
    if (v.e_err != 0) begin
      v.e_faddr = a;
      v.e_fcnt  = (m_fcnt < 255) ? m_fcnt + 1 : 255;
    end
    return v;
  endfunction

  task automatic run_vec(input string id, input vec_t v, input int hold);
    int             end_c;
    int             sl;
    logic [NIO-1:0] excl;
    end_c = (v.e_ready != 0) ? v.e_ready : v.e_err;
    sl    = int'(v.addr[5:0]);
    excl  = (v.addr[29:22] == IOC && sl < NIO) ? (NIO'(1) << sl) : '0;
    address = v.addr;
    read    = v.rd;
    write   = v.wr;
    io_ack  = NIO'($urandom) & ~excl;
    for (int c = 1; c <= end_c + hold; c++) begin
      tick();
      io_ack = NIO'($urandom) & ~excl;
      if (c == v.ack) io_ack = io_ack | excl;
      check($sformatf("%s c%0d class_cs", id, c), 64'(class_cs), 64'((c < end_c) ? v.e_ccs : '0));
      check($sformatf("%s c%0d io_cs", id, c), 64'(io_cs), 64'((c < end_c) ? v.e_ios : '0));
      check($sformatf("%s c%0d ready", id, c), 64'(ready), 64'(c == v.e_ready));
      check($sformatf("%s c%0d bus_error", id, c), 64'(bus_error), 64'(v.e_err != 0 && c >= v.e_err));
    end
    read   = 1'b0;
    write  = 1'b0;
    io_ack = '0;
    tick();
    check($sformatf("%s bus_error_clear", id), 64'(bus_error), 64'(0));
    check($sformatf("%s ready_idle", id), 64'(ready), 64'(0));
    check($sformatf("%s data_in", id), 64'(data_in), 64'(v.e_data));
    check($sformatf("%s fault_address", id), 64'(fault_address), 64'(v.e_faddr));
    check($sformatf("%s fault_count", id), 64'(fault_count), 64'(v.e_fcnt));
  endtask

  task automatic check_all_zero(input string id);
    check({id, " class_cs"}, 64'(class_cs), 64'(0));
    check({id, " io_cs"}, 64'(io_cs), 64'(0));
    check({id, " data_in"}, 64'(data_in), 64'(0));
    check({id, " ready"}, 64'(ready), 64'(0));
    check({id, " bus_error"}, 64'(bus_error), 64'(0));
    check({id, " fault_address"}, 64'(fault_address), 64'(0));
    check({id, " fault_count"}, 64'(fault_count), 64'(0));
  endtask

  initial begin
    vec_t        v;
    logic [7:0]  hb;
    logic [5:0]  sl;
    logic [29:0] a;
    logic        r;
    logic        w;
    int          rw;

    // addr, rd, wr, ack, class_cs, io_cs, ready@, error@, data_in, fault_address, fault_count
    tbl[0]  = '{30'h0040_0004, 1'b1, 1'b0, 0, 4'b0010, 11'h000, 2, 0, 32'hDEAD_BEEF, 30'h0, 0};
    tbl[1]  = '{30'h03C0_0006, 1'b0, 1'b1, 3, 4'b0000, 11'h040, 4, 0, 32'hDEAD_BEEF, 30'h0, 0};
    tbl[2]  = '{30'h03C0_000B, 1'b1, 1'b0, 0, 4'b0000, 11'h000, 0, 1, 32'hDEAD_BEEF, 30'h03C0_000B, 1};
    tbl[3]  = '{30'h03C0_0000, 1'b1, 1'b0, 0, 4'b0000, 11'h001, 0, 6, 32'hDEAD_BEEF, 30'h03C0_0000, 2};
    tbl[4]  = '{30'h03C0_000A, 1'b1, 1'b0, 1, 4'b0000, 11'h400, 2, 0, 32'h10DA_000A, 30'h03C0_0000, 2};
    tbl[5]  = '{30'h0080_0000, 1'b1, 1'b1, 0, 4'b0000, 11'h000, 0, 1, 32'h10DA_000A, 30'h0080_0000, 3};
    tbl[6]  = '{30'h00C0_0100, 1'b1, 1'b0, 0, 4'b1000, 11'h000, 2, 0, 32'hC1A5_0003, 30'h0080_0000, 3};
    tbl[7]  = '{30'h0100_0000, 1'b1, 1'b0, 0, 4'b0000, 11'h000, 0, 1, 32'hC1A5_0003, 30'h0100_0000, 4};
    tbl[8]  = '{30'h03C0_0002, 1'b1, 1'b0, 5, 4'b0000, 11'h004, 6, 0, 32'h10DA_0002, 30'h0100_0000, 4};
    tbl[9]  = '{30'h0000_0040, 1'b0, 1'b1, 0, 4'b0001, 11'h000, 2, 0, 32'h10DA_0002, 30'h0100_0000, 4};
    tbl[10] = '{30'h3FC0_0000, 1'b0, 1'b1, 0, 4'b0000, 11'h000, 0, 1, 32'h10DA_0002, 30'h3FC0_0000, 5};
    tbl[11] = '{30'h03C4_8D01, 1'b1, 1'b0, 2, 4'b0000, 11'h002, 3, 0, 32'h10DA_0001, 30'h3FC0_0000, 5};

    for (int k = 0; k < NC; k++) cword[k] = (k == 1) ? 32'hDEAD_BEEF : (32'hC1A5_0000 | 32'(k));
    for (int s = 0; s < NIO; s++) iword[s] = 32'h10DA_0000 | 32'(s);
    pack_words();

    n_reset = 1'b0;
    address = '0;
    read    = 1'b0;
    write   = 1'b0;
    io_ack  = '0;
    repeat (3) tick();
    check_all_zero("reset");
    n_reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i], 1);
    end

    m_data  = tbl[11].e_data;
    m_faddr = tbl[11].e_faddr;
    m_fcnt  = tbl[11].e_fcnt;

    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < NC; k++) cword[k] = $urandom;
      for (int s = 0; s < NIO; s++) iword[s] = $urandom;
      pack_words();
      sl = 6'($urandom);
      case ($urandom_range(0, 3))
        0:       hb = 8'($urandom_range(0, NC - 1));
        1:       begin hb = IOC; sl = 6'($urandom_range(0, NIO - 1)); end
        2:       hb = IOC;
        default: hb = 8'($urandom);
      endcase
      a  = {hb, 16'($urandom), sl};
      rw = $urandom_range(0, 9);
      r  = (rw == 0) || (rw < 5);
      w  = (rw == 0) || (rw >= 5);
      v  = predict(a, r, w, $urandom_range(0, TO + 2));
      run_vec($sformatf("rnd%0d", i), v, $urandom_range(0, 2));
      m_data  = v.e_data;
      m_faddr = v.e_faddr;
      m_fcnt  = v.e_fcnt;
    end

    for (int i = 0; i < 256; i++) begin
      hb = 8'($urandom_range(16, 255));
      a  = {hb, 22'($urandom)};
      v  = predict(a, 1'b1, 1'b0, 0);
      run_vec($sformatf("sat%0d", i), v, 0);
      m_data  = v.e_data;
      m_faddr = v.e_faddr;
      m_fcnt  = v.e_fcnt;
    end
    check("fault_count_saturated", 64'(fault_count), 64'(255));

    // Reset in the middle of an IO wait abandons the cycle silently.
    address = 30'h03C0_0003;
    read    = 1'b1;
    io_ack  = '0;
    tick();
    check("rst_seq io_cs", 64'(io_cs), 64'(11'h008));
    tick();
    tick();
    n_reset = 1'b0;
    tick();
    check_all_zero("rst_seq");
    n_reset = 1'b1;
    read    = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("rst_seq post%0d ready", c), 64'(ready), 64'(0));
      check($sformatf("rst_seq post%0d bus_error", c), 64'(bus_error), 64'(0));
      check($sformatf("rst_seq post%0d io_cs", c), 64'(io_cs), 64'(0));
      check($sformatf("rst_seq post%0d fault_count", c), 64'(fault_count), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised address decoder and bus-cycle controller between the maxicore32 processor and its memories and IO devices, replacing the ad-hoc combinational chip-select and read-mux logic in each board top level. It decodes the device class from address[31:24] and the IO register slot from address[7:2], drives registered one-hot chip selects, and tracks each bus cycle through a ready handshake. It returns registered read data and raises bus_error on unmapped addresses or device timeouts, capturing the faulting address for software.

## Interface
Parameters:
- NUM_CLASSES, 4: memory-like classes mapped at high byte 0..NUM_CLASSES-1; must be ≤ IO_CLASS.
- IO_CLASS, 8'h0f: high byte selecting IO space.
- NUM_IO, 11: IO register slots, indexed by address[7:2]; 1..64.
- MEM_LATENCY, 1: fixed cycles from class select to valid class data; ≥1.
- TIMEOUT, 255: maximum cycles to wait for an IO ack; 1..255.

Ports:
- clock  in  1: CPU clock; all logic on the rising edge.
- n_reset  in  1: active-low reset; **single clock, synchronous active-low reset**.
- address  in  30: processor address[31:2].
- read  in  1: processor read request, held until ready or bus_error.
- write  in  1: processor write request, held until ready or bus_error.
- class_cs  out  NUM_CLASSES: one-hot registered class select.
- io_cs  out  NUM_IO: one-hot registered IO slot select.
- class_data  in  32*NUM_CLASSES: read data per class; slice k = class k.
- io_data  in  32*NUM_IO: read data per IO slot.
- io_ack  in  NUM_IO: per-slot completion, sampled while the slot is selected.
- data_in  out  32: registered read data to the processor.
- ready  out  1: one-cycle cycle-complete strobe.
- bus_error  out  1: held from fault until read and write both drop.
- fault_address  out  30: address of the most recent fault.
- fault_count  out  8: number of faults, saturating at 255.

## Operation
- FSM states: IDLE, MEM_WAIT, IO_WAIT, DONE, ERROR.
- IDLE: on read|write, decode the address.
  - High byte < NUM_CLASSES: assert class_cs[high], load the latency counter with MEM_LATENCY, go to MEM_WAIT.
  - High byte == IO_CLASS and slot < NUM_IO: assert io_cs[slot], load the timeout counter with TIMEOUT, go to IO_WAIT.
  - Otherwise: go to ERROR.
- read and write both high in IDLE is treated as a fault.
- MEM_WAIT: decrement the counter. When it reaches 0, latch the selected class_data into data_in if read, pulse ready, and go to DONE.
- IO_WAIT: if io_ack[slot] is set, latch the selected io_data into data_in if read, pulse ready, and go to DONE. Otherwise decrement the counter; on reaching 0 go to ERROR.
- DONE: drop all selects. When read and write are both low, go to IDLE.
- ERROR: bus_error=1 and all selects low. fault_address is loaded and fault_count incremented (saturating) on the entry cycle only. When read and write are both low, go to IDLE.
- data_in holds its last value except when it is loaded on a completed read; write cycles never load it.
- Ack from an IO slot that is not selected is ignored.

## Timing
- Reset values: all selects 0, data_in 0, ready 0, bus_error 0, fault_address 0, fault_count 0, state IDLE.
- Reset mid-cycle abandons the cycle without a ready pulse and without a fault entry.
- Selects are valid the cycle after read/write is first sampled in IDLE.
- Memory read: ready and data_in are valid MEM_LATENCY+1 cycles after the request is sampled.
- IO read: ready and data_in are valid one cycle after io_ack is sampled high. An ack in the first select cycle gives a total latency of 2.
- Timeout: bus_error asserts TIMEOUT+1 cycles after io_cs asserts with no ack.
- Unmapped address: bus_error asserts 1 cycle after the request.
- Back-to-back cycles need at least one idle cycle (read=write=0) between them.

## Structure
- Shared package bus_pkg: IO_CLASS and the slot byte offsets (LED 0x00 … I2C_CONTROL 0x28), the class numbers (PROGRAM 0, MAP 1, STATUS 2, LEVELS 3), and the FSM state enum.
- One sub-module, bus_cycle_timer: a loadable down-counter with a zero flag, shared by the memory-latency and IO-timeout paths.
- Decode and data muxing stay in bus_decoder.

## Test plan
- Read of class 1 (address 0x01000010), MEM_LATENCY=1, class_data slice 1 = 0xDEADBEEF -> class_cs=4'b0010 one cycle after the request; ready with data_in=0xDEADBEEF at cycle 2; bus_error stays 0.
- Write to IO slot 0x18 with io_ack on the 3rd select cycle -> io_cs[6] high for 3 cycles; ready 1 cycle after the ack; data_in unchanged.
- Read of 0x0F00002C (slot 11, NUM_IO=11) -> bus_error at cycle 1; fault_address=0x0F00002C>>2; fault_count=1; bus_error clears the cycle after read drops.
- IO read with TIMEOUT=4 and no ack -> bus_error 5 cycles after io_cs asserts; io_cs deasserts; no ready pulse.
- 256 consecutive unmapped reads -> fault_count saturates at 255; n_reset low during an IO_WAIT -> all outputs 0 on the next edge and no fault logged.
